// File: rtl/rt_pkg.sv
// Shared definitions for the reaction timer: FSM state encoding and the
// default LFSR feedback polynomial.
package rt_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COUNTUP = 3'd1,
      S_HOLD    = 3'd2,
      S_GO      = 3'd3,
      S_DONE    = 3'd4,
      S_FALSE   = 3'd5
   } state_t;

   // x^14 + x^13 + x^12 + x^2 + 1
   localparam logic [13:0] DEFAULT_LFSR_TAPS = 14'h3802;

endpackage

// File: rtl/lfsr_n.sv
// Free-running Fibonacci LFSR; feedback is the XOR of the masked taps,
// shifted in at the LSB.
module lfsr_n
   import rt_pkg::*;
#(
   parameter int             W    = 14,
   parameter logic [W-1:0]   TAPS = W'(DEFAULT_LFSR_TAPS),
   parameter logic [W-1:0]   SEED = W'(1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] q
);

   logic fb;

   assign fb = ^(q & TAPS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= SEED;
      end else if (en) begin
         q <= {q[W-2:0], fb};
      end
   end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-timer engine: light-up sequence, LFSR-random hold, then millisecond
// measurement of the response with false-start, timeout and best-time tracking.
module reaction_timer_core
   import rt_pkg::*;
#(
   parameter int                 N_LIGHTS     = 10,
   parameter int                 LFSR_W       = 14,
   parameter logic [LFSR_W-1:0]  LFSR_TAPS    = LFSR_W'(DEFAULT_LFSR_TAPS),
   parameter logic [LFSR_W-1:0]  LFSR_SEED    = LFSR_W'(1),
   parameter int                 TIME_W       = 14,
   parameter int                 DELAY_W      = 12,
   parameter int                 MIN_DELAY_MS = 250
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick_ms,
   input  logic                tick_step,
   input  logic                trigger,
   output logic [N_LIGHTS-1:0] ledr,
   output logic [TIME_W-1:0]   reaction_ms,
   output logic                valid,
   output logic                false_start,
   output logic                timeout,
   output logic [TIME_W-1:0]   best_ms,
   output logic                busy
);

   localparam logic [N_LIGHTS-1:0] LEDR_FULL = {N_LIGHTS{1'b1}};
   localparam logic [TIME_W-1:0]   RT_LAST   = {{(TIME_W-1){1'b1}}, 1'b0};

   state_t                state_reg, state_next;
   logic                  trigger_d_reg;
   logic                  trig_edge;
   logic [N_LIGHTS-1:0]   ledr_reg, ledr_next;
   logic [TIME_W-1:0]     delay_cnt_reg, delay_cnt_next;
   logic [TIME_W-1:0]     rt_cnt_reg, rt_cnt_next;
   logic [TIME_W-1:0]     reaction_reg, reaction_next;
   logic                  valid_reg, valid_next;
   logic                  false_start_reg, false_start_next;
   logic                  timeout_reg, timeout_next;
   logic [TIME_W-1:0]     best_reg, best_next;

   logic [LFSR_W-1:0]     lfsr_q;
   logic [TIME_W:0]       delay_sum;
   logic [TIME_W-1:0]     delay_init;
   logic [TIME_W:0]       capture_sum;
   logic [TIME_W-1:0]     capture;

   lfsr_n #(
      .W    (LFSR_W),
      .TAPS (LFSR_TAPS),
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .q   (lfsr_q)
   );

   // Only the low DELAY_W bits set the delay; the rest just keep the sequence long.
   generate
      if (DELAY_W < LFSR_W) begin : g_lfsr_spare
         logic lfsr_unused;
         assign lfsr_unused = ^lfsr_q[LFSR_W-1:DELAY_W];
      end
   endgenerate

   assign trig_edge = trigger & ~trigger_d_reg;

   assign delay_sum  = {{(TIME_W+1-DELAY_W){1'b0}}, lfsr_q[DELAY_W-1:0]}
                     + (TIME_W+1)'(MIN_DELAY_MS);
   assign delay_init = delay_sum[TIME_W] ? {TIME_W{1'b1}} : delay_sum[TIME_W-1:0];

   // A tick_ms landing in the same cycle as the press still counts.
   assign capture_sum = {1'b0, rt_cnt_reg} + {{TIME_W{1'b0}}, tick_ms};
   assign capture     = capture_sum[TIME_W] ? {TIME_W{1'b1}} : capture_sum[TIME_W-1:0];

   always_comb begin
      state_next       = state_reg;
      ledr_next        = ledr_reg;
      delay_cnt_next   = delay_cnt_reg;
      rt_cnt_next      = rt_cnt_reg;
      reaction_next    = reaction_reg;
      valid_next       = 1'b0;
      false_start_next = false_start_reg;
      timeout_next     = timeout_reg;
      best_next        = best_reg;

      case (state_reg)
         S_IDLE, S_DONE, S_FALSE: begin
            if (trig_edge) begin
               state_next       = S_COUNTUP;
               ledr_next        = '0;
               false_start_next = 1'b0;
               timeout_next     = 1'b0;
            end
         end
         S_COUNTUP: begin
            if (trig_edge) begin
               state_next       = S_FALSE;
               false_start_next = 1'b1;
            end else if (tick_step) begin
               if (ledr_reg == LEDR_FULL) begin
                  state_next     = S_HOLD;
                  delay_cnt_next = delay_init;
               end else begin
                  ledr_next = {ledr_reg[N_LIGHTS-2:0], 1'b1};
               end
            end
         end
         S_HOLD: begin
            if (trig_edge) begin
               state_next       = S_FALSE;
               false_start_next = 1'b1;
            end else if (tick_ms) begin
               if (delay_cnt_reg == TIME_W'(1)) begin
                  state_next  = S_GO;
                  ledr_next   = '0;
                  rt_cnt_next = '0;
               end else begin
                  delay_cnt_next = delay_cnt_reg - TIME_W'(1);
               end
            end
         end
         S_GO: begin
            if (trig_edge) begin
               state_next    = S_DONE;
               reaction_next = capture;
               valid_next    = 1'b1;
               if (capture < best_reg) begin
                  best_next = capture;
               end
            end else if (tick_ms) begin
               if (rt_cnt_reg == RT_LAST) begin
                  state_next    = S_DONE;
                  rt_cnt_next   = {TIME_W{1'b1}};
                  reaction_next = {TIME_W{1'b1}};
                  timeout_next  = 1'b1;
                  valid_next    = 1'b1;
               end else begin
                  rt_cnt_next = rt_cnt_reg + TIME_W'(1);
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= S_IDLE;
         trigger_d_reg   <= 1'b0;
         ledr_reg        <= '0;
         delay_cnt_reg   <= '0;
         rt_cnt_reg      <= '0;
         reaction_reg    <= '0;
         valid_reg       <= 1'b0;
         false_start_reg <= 1'b0;
         timeout_reg     <= 1'b0;
         best_reg        <= {TIME_W{1'b1}};
      end else begin
         state_reg       <= state_next;
         trigger_d_reg   <= trigger;
         ledr_reg        <= ledr_next;
         delay_cnt_reg   <= delay_cnt_next;
         rt_cnt_reg      <= rt_cnt_next;
         reaction_reg    <= reaction_next;
         valid_reg       <= valid_next;
         false_start_reg <= false_start_next;
         timeout_reg     <= timeout_next;
         best_reg        <= best_next;
      end
   end

   assign ledr        = ledr_reg;
   assign reaction_ms = reaction_reg;
   assign valid       = valid_reg;
   assign false_start = false_start_reg;
   assign timeout     = timeout_reg;
   assign best_ms     = best_reg;
   assign busy        = (state_reg == S_COUNTUP) || (state_reg == S_HOLD) || (state_reg == S_GO);

endmodule
